// File: rtl/dkong3_snd_seq.sv
// ---------------------------------------------------------------------------
// dkong3_snd_seq
//   Sequencer and command mailbox for the sound sub-CPU / APU subsystem.
//   - Divides the 12 MHz clock into a one-clock-wide CPU/APU clock enable and
//     keeps the APU odd/even phase.
//   - Buffers main-CPU sound commands in a small FIFO that the sub-CPU reads
//     at 0x4016 (data, pops) and 0x4017 (status). 0x4018 is the NMI control
//     register (bit0 = VBLANK NMI enable, bit1 = command NMI enable).
//   - Generates sub-CPU NMIs from VBLANK rising edges and command arrival.
//
// Ports
//   I_CLK_12M      in   system clock, rising edge
//   I_RESET        in   synchronous active-high reset
//   I_CMD_WR       in   main-CPU command strobe (one clock)
//   I_CMD_DATA     in   command byte
//   I_VBLANK       in   vertical blank level
//   I_SUB_ADDR     in   sub-CPU address
//   I_SUB_DO       in   sub-CPU write data
//   I_SUB_RNW      in   sub-CPU read(1)/write(0)
//   O_CPU_CE       out  CPU/APU clock enable
//   O_ODD_OR_EVEN  out  APU odd/even phase
//   O_SUB_NMIn     out  sub-CPU NMI, active low
//   O_SUB_DBI      out  read data for decoded registers, 0x00 otherwise
//   O_CMD_COUNT    out  FIFO occupancy
//   O_CMD_OVF      out  sticky FIFO overflow flag
//   O_FSM_STATE    out  NMI FSM state (0 idle, 1 assert, 2 recover)
//
// Handshake: there is no valid/ready pair. A sub-CPU access takes effect only
// on a clock where O_CPU_CE=1 ("qualified"); I_CMD_WR is accepted whenever
// the FIFO has room (or is being popped in the same clock), otherwise the
// byte is dropped and O_CMD_OVF is set.
// ---------------------------------------------------------------------------
module dkong3_snd_seq #(
    parameter int CE_DIV    = 7,
    parameter int NMI_WIDTH = 8,
    parameter int FIFO_AW   = 2
) (
    input  logic               I_CLK_12M,
    input  logic               I_RESET,
    input  logic               I_CMD_WR,
    input  logic [7:0]         I_CMD_DATA,
    input  logic               I_VBLANK,
    input  logic [15:0]        I_SUB_ADDR,
    input  logic [7:0]         I_SUB_DO,
    input  logic               I_SUB_RNW,
    output logic               O_CPU_CE,
    output logic               O_ODD_OR_EVEN,
    output logic               O_SUB_NMIn,
    output logic [7:0]         O_SUB_DBI,
    output logic [FIFO_AW:0]   O_CMD_COUNT,
    output logic               O_CMD_OVF,
    output logic [1:0]         O_FSM_STATE
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    // ---------------- clock enable divider and phase ----------------
    logic [3:0] div_q;

    // CE is registered: it is raised one clock early so that it is high
    // exactly in the clock where the divider sits at CE_DIV-1.
    always_ff @(posedge I_CLK_12M) begin
        if (I_RESET) begin
            div_q         <= 4'd0;
            O_CPU_CE      <= 1'b0;
            O_ODD_OR_EVEN <= 1'b0;
        end else begin
            div_q    <= (div_q == 4'(CE_DIV - 1)) ? 4'd0 : div_q + 4'd1;
            O_CPU_CE <= (div_q == 4'(CE_DIV - 2));
            if (O_CPU_CE) begin
                O_ODD_OR_EVEN <= ~O_ODD_OR_EVEN;
            end
        end
    end

    // ---------------- address decode ----------------
    logic sel_data, sel_stat, sel_ctrl;
    assign sel_data = (I_SUB_ADDR == 16'h4016);
    assign sel_stat = (I_SUB_ADDR == 16'h4017);
    assign sel_ctrl = (I_SUB_ADDR == 16'h4018);

    // ---------------- command FIFO ----------------
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               ovf;
    logic               empty, full;
    logic               pop, push, ovf_set;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop     = O_CPU_CE && I_SUB_RNW && sel_data && !empty;
    // A pop in the same clock frees the slot, so a full FIFO still accepts.
    assign push    = I_CMD_WR && (!full || pop);
    assign ovf_set = I_CMD_WR && full && !pop;

    always_ff @(posedge I_CLK_12M) begin
        if (I_RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ovf_set) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is only presented when not empty.
    always_ff @(posedge I_CLK_12M) begin
        if (push) begin
            mem[wr_ptr] <= I_CMD_DATA;
        end
    end

    assign O_CMD_COUNT = count;
    assign O_CMD_OVF   = ovf;

    // ---------------- control register ----------------
    logic [1:0] ctrl;
    logic       ctrl_wr;
    logic       ctrl_clr_pend;
    logic       unused_sub_do;

    assign ctrl_wr       = O_CPU_CE && !I_SUB_RNW && sel_ctrl;
    assign ctrl_clr_pend = ctrl_wr && (I_SUB_DO[1:0] == 2'b00);
    assign unused_sub_do = ^I_SUB_DO[7:2];

    always_ff @(posedge I_CLK_12M) begin
        if (I_RESET) begin
            ctrl <= 2'b00;
        end else if (ctrl_wr) begin
            ctrl <= I_SUB_DO[1:0];
        end
    end

    // ---------------- read mux ----------------
    logic [4:0] count5;
    assign count5 = 5'(count);

    always_comb begin
        O_SUB_DBI = 8'h00;
        if (I_SUB_RNW) begin
            if (sel_data && !empty) begin
                O_SUB_DBI = mem[rd_ptr];
            end else if (sel_stat) begin
                O_SUB_DBI = {empty, full, ovf, count5};
            end else if (sel_ctrl) begin
                O_SUB_DBI = {6'b0, ctrl};
            end
        end
    end

    // ---------------- NMI request and FSM ----------------
    logic vbl_prev;
    logic vbl_edge;
    logic req;

    always_ff @(posedge I_CLK_12M) begin
        if (I_RESET) begin
            vbl_prev <= 1'b0;
        end else begin
            vbl_prev <= I_VBLANK;
        end
    end

    assign vbl_edge = I_VBLANK & ~vbl_prev;
    assign req      = (vbl_edge & ctrl[0]) | (push & ctrl[1]);

    state_t     state_q, state_d;
    logic [3:0] pulse_q, pulse_d;
    logic       pending_q, pending_d;

    always_ff @(posedge I_CLK_12M) begin
        if (I_RESET) begin
            state_q   <= ST_IDLE;
            pulse_q   <= 4'd0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pulse_d    = pulse_q;
        pending_d  = pending_q;
        O_SUB_NMIn = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (req || pending_q) begin
                    state_d   = ST_ASSERT;
                    pulse_d   = 4'd0;
                    pending_d = 1'b0;
                end
            end
            ST_ASSERT: begin
                O_SUB_NMIn = 1'b0;
                if (req) begin
                    pending_d = 1'b1;
                end
                if (O_CPU_CE) begin
                    if (pulse_q == 4'(NMI_WIDTH - 1)) begin
                        state_d = ST_RECOVER;
                        pulse_d = 4'd0;
                    end else begin
                        pulse_d = pulse_q + 4'd1;
                    end
                end
            end
            ST_RECOVER: begin
                if (req) begin
                    pending_d = 1'b1;
                end
                // Two CE pulses high so the CPU always sees a fresh edge.
                if (O_CPU_CE) begin
                    if (pulse_q == 4'd1) begin
                        state_d = ST_IDLE;
                        pulse_d = 4'd0;
                    end else begin
                        pulse_d = pulse_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pulse_d = 4'd0;
            end
        endcase
        // Disabling the NMI sources drops a queued request but never cuts
        // short a pulse already on the wire.
        if (ctrl_clr_pend) begin
            pending_d = 1'b0;
        end
    end

    assign O_FSM_STATE = state_q;

endmodule
